// File: rtl/uart_tx_queue_if.sv
// Write-side valid/ready handshake for the UART transmit queue.
// The master produces characters; the slave (queue) accepts them when wr_ready is high.
interface uart_tx_queue_if #(
    parameter int unsigned DATA_W = 7
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_queue.sv
// FIFO feeder for a UART transmitter: pops one character per frame and paces tx_start pulses.
// Optional synchronous queue flush is enabled with the UART_TXQ_FLUSH_EN macro.
module uart_tx_queue #(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned FRAME_CYCLES = 8,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_queue_if.slave         wr,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] level
`ifdef UART_TXQ_FLUSH_EN
    ,
    input  logic                   flush
`endif
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LvlW   = PtrW + 1;
    localparam int unsigned Period = FRAME_CYCLES + GAP_CYCLES;
    localparam int unsigned TimerW = $clog2(Period + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic flush_w;
    logic push;
    logic pop;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Readiness depends on the registered level only, so a same-cycle pop never frees a full slot.
    assign wr.wr_ready = (level_q != LvlW'(DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready && !flush_w;
    assign pop         = (state_q == StIdle) && (level_q != '0) && !flush_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (flush_w) begin
            wr_ptr_d = '0;
            level_d  = '0;
        end else if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        timer_d    = timer_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + PtrW'(1);
                    state_d   = StStart;
                end
            end
            StStart: begin
                tx_start_d = 1'b1;
                timer_d    = TimerW'(Period - 1);
                state_d    = StWait;
            end
            StWait: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_w) begin
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            timer_q    <= timer_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr.wr_data;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_busy  = (state_q != StIdle);
    assign level    = level_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with default parameters.
// Flush scenario is exercised only when UART_TXQ_FLUSH_EN is defined.
module tb_uart_tx_queue;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       tx_start;
    logic [6:0] tx_data;
    logic       tx_busy;
    logic [3:0] level;

    int checks   = 0;
    int failures = 0;

    logic [6:0] cap[$];
    logic       saw_full_block;
    logic [3:0] max_level;

    uart_tx_queue_if #(.DATA_W(7)) wr_if ();

    uart_tx_queue #(
        .DATA_W      (7),
        .DEPTH       (8),
        .FRAME_CYCLES(8),
        .GAP_CYCLES  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr_if.slave),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .level   (level)
`ifdef UART_TXQ_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: record every start pulse and the fullest the queue ever got.
    always @(negedge clk) begin
        if (rst_n && tx_start) cap.push_back(tx_data);
        if (rst_n && level > max_level) max_level = level;
        if (rst_n && level == 4'd8 && !wr_if.wr_ready) saw_full_block = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [6:0] d);
        int  n;
        logic ok;
        n = 0;
        ok = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        do begin
            @(negedge clk);
            ok = wr_if.wr_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        wr_if.wr_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_accept: data=%h not accepted after %0d cycles, required acceptance", d, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (tx_busy) begin
            failures++;
            $display("FAIL %s_idle: tx_busy=%b after %0d cycles, required 0", name, tx_busy, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        checks++;
        if (level !== 4'd0 || tx_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 7'h00
            || wr_if.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_initial: level=%0d busy=%b start=%b data=%h ready=%b, required 0 0 0 00 1",
                     level, tx_busy, tx_start, tx_data, wr_if.wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        write_char(7'h11);
        step(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || tx_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 7'h00
            || wr_if.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: level=%0d busy=%b start=%b data=%h ready=%b, required 0 0 0 00 1",
                     level, tx_busy, tx_start, tx_data, wr_if.wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single_char;
        write_char(7'h41);
        step(1);
        checks++;
        if (tx_data !== 7'h41 || tx_busy !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_e1: data=%h busy=%b start=%b, required 41 1 0", tx_data, tx_busy, tx_start);
        end
        step(1);
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("FAIL single_e2_start: tx_start=%b, required 1", tx_start);
        end
        step(1);
        checks++;
        if (tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_e3_start: tx_start=%b, required 0", tx_start);
        end
        step(7);
        checks++;
        if (tx_busy !== 1'b1 || tx_data !== 7'h41) begin
            failures++;
            $display("FAIL single_e10_busy: busy=%b data=%h, required 1 41", tx_busy, tx_data);
        end
        step(2);
        checks++;
        if (tx_busy !== 1'b0 || tx_data !== 7'h41) begin
            failures++;
            $display("FAIL single_e12_idle: busy=%b data=%h, required 0 41", tx_busy, tx_data);
        end
    endtask

    task automatic test_fill;
        int n;
        cap.delete();
        max_level = 4'd0;
        saw_full_block = 1'b0;
        for (int i = 1; i <= 9; i++) write_char(7'(i));
        n = 0;
        while (cap.size() < 9 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (max_level !== 4'd8) begin
            failures++;
            $display("FAIL fill_max_level: level peak=%0d, required 8", max_level);
        end
        checks++;
        if (saw_full_block !== 1'b1) begin
            failures++;
            $display("FAIL fill_ready_low: full with wr_ready=0 seen=%b, required 1", saw_full_block);
        end
        checks++;
        if (cap.size() != 9) begin
            failures++;
            $display("FAIL fill_count: starts=%0d, required 9", cap.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (i < cap.size()) begin
                checks++;
                if (cap[i] !== 7'(i + 1)) begin
                    failures++;
                    $display("FAIL fill_order[%0d]: data=%h, required %h", i, cap[i], 7'(i + 1));
                end
            end
        end
        wait_idle("fill");
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_d;
        logic       exp_s;
        write_char(7'h55);
        write_char(7'h2A);
        write_char(7'h7F);
        // Now just after E2: first start pulse must be high.
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 7'h55) begin
            failures++;
            $display("FAIL b2b_first: start=%b data=%h, required 1 55", tx_start, tx_data);
        end
        for (int k = 3; k <= 33; k++) begin
            step(1);
            exp_d = (k <= 11) ? 7'h55 : (k <= 22) ? 7'h2A : 7'h7F;
            exp_s = (k == 13 || k == 24);
            checks++;
            if (tx_data !== exp_d || tx_start !== exp_s) begin
                failures++;
                $display("FAIL b2b_e%0d: data=%h start=%b, required %h %b", k, tx_data, tx_start, exp_d, exp_s);
            end
        end
        checks++;
        if (tx_busy !== 1'b0 || level !== 4'd0) begin
            failures++;
            $display("FAIL b2b_end: busy=%b level=%0d, required 0 0", tx_busy, level);
        end
    endtask

    task automatic test_reset_mid_wait;
        for (int i = 0; i < 4; i++) write_char(7'(8'h21 + i));
        step(2);
        checks++;
        if (level !== 4'd3 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_pre: level=%0d busy=%b, required 3 1", level, tx_busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || tx_busy !== 1'b0 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_async: level=%0d busy=%b start=%b, required 0 0 0", level, tx_busy, tx_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cap.delete();
        step(30);
        checks++;
        if (cap.size() != 0 || level !== 4'd0 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_quiet: starts=%0d level=%0d busy=%b, required 0 0 0", cap.size(), level, tx_busy);
        end
        write_char(7'h5A);
        step(2);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 7'h5A) begin
            failures++;
            $display("FAIL rst_wait_restart: start=%b data=%h, required 1 5a", tx_start, tx_data);
        end
        wait_idle("rst_wait");
    endtask

`ifdef UART_TXQ_FLUSH_EN
    task automatic test_flush;
        cap.delete();
        for (int i = 0; i < 5; i++) write_char(7'(8'h31 + i));
        checks++;
        if (level !== 4'd4 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: level=%0d busy=%b, required 4 1", level, tx_busy);
        end
        flush = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 7'h33;
        step(1);
        flush = 1'b0;
        wr_if.wr_valid = 1'b0;
        checks++;
        if (level !== 4'd0 || tx_busy !== 1'b1 || tx_data !== 7'h31) begin
            failures++;
            $display("FAIL flush_now: level=%0d busy=%b data=%h, required 0 1 31", level, tx_busy, tx_data);
        end
        step(40);
        checks++;
        if (cap.size() != 1 || level !== 4'd0 || tx_busy !== 1'b0 || tx_data !== 7'h31) begin
            failures++;
            $display("FAIL flush_after: starts=%0d level=%0d busy=%b data=%h, required 1 0 0 31",
                     cap.size(), level, tx_busy, tx_data);
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 7'h00;
        saw_full_block = 1'b0;
        max_level      = 4'd0;
        test_reset();
        test_single_char();
        test_fill();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef UART_TXQ_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
